// File: rtl/simple_pkg.sv
// Shared types and constants for the SIMPLE pipeline memory port.
//   mem_state_t : scheduler FSM states
//   MEM_LAT_MIN/MAX : legal range of the memory latency parameter
//   LAT_CNT_W   : width of the latency down-counter
package simple_pkg;

  localparam int unsigned MEM_LAT_MIN = 1;
  localparam int unsigned MEM_LAT_MAX = 4;
  localparam int unsigned LAT_CNT_W   = 3;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FETCH_WAIT = 2'd1,
    DATA_WAIT  = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_port_sched.sv
// Arbiter/sequencer for the single shared memory port of the SIMPLE pipeline.
// Data accesses win over instruction fetch; one access is in flight at a time.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   if_req/if_addr             : fetch request (in); if_rdata/if_valid (out)
//   dm_req/dm_we/dm_addr/dm_wdata : data request (in); dm_rdata/dm_done (out)
//   flush                      : taken branch, cancels pending/in-flight fetch
//   stall_if/stall_mem         : combinational pipeline freeze lines
//   mem_en/mem_we/mem_addr/mem_wdata (out), mem_rdata (in) : RAM port
//   busy                       : scheduler not in IDLE
// Requesters drop or replace *_req in the cycle their completion pulse is
// high; a request still present in that IDLE cycle is taken as a new access.
module mem_port_sched
  import simple_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  input  logic              flush,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // Reject latencies the 3-bit counter and the pipeline timing do not support.
  if ((MEM_LAT < MEM_LAT_MIN) || (MEM_LAT > MEM_LAT_MAX)) begin : g_lat_check
    $error("mem_port_sched: MEM_LAT out of range 1..4");
  end

  mem_state_t             state_q, state_d;
  logic [LAT_CNT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic                   discard_q, discard_d;
  logic                   mem_en_q, mem_en_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]      if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]      dm_rdata_q, dm_rdata_d;
  logic                   if_valid_q, if_valid_d;
  logic                   dm_done_q, dm_done_d;
  logic                   busy_q, busy_d;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lat_cnt_q   <= '0;
      discard_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_done_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      discard_q   <= discard_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_valid_q  <= if_valid_d;
      dm_done_q   <= dm_done_d;
      busy_q      <= busy_d;
    end
  end

  // Issue decision, latency countdown and completion.
  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    discard_d   = discard_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_valid_d  = 1'b0;
    dm_done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        discard_d = 1'b0;
        if (dm_req) begin
          state_d     = DATA_WAIT;
          mem_en_d    = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          lat_cnt_d   = LAT_CNT_W'(MEM_LAT);
        end else if (if_req && !flush) begin
          state_d    = FETCH_WAIT;
          mem_en_d   = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          lat_cnt_d  = LAT_CNT_W'(MEM_LAT);
        end
      end

      FETCH_WAIT: begin
        if (lat_cnt_q == '0) begin
          state_d   = IDLE;
          discard_d = 1'b0;
          // A flush arriving in the capture cycle cancels the fetch as well.
          if (!(discard_q || flush)) begin
            if_rdata_d = mem_rdata;
            if_valid_d = 1'b1;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_CNT_W'(1);
          if (flush) begin
            discard_d = 1'b1;
          end
        end
      end

      DATA_WAIT: begin
        if (lat_cnt_q == '0) begin
          state_d   = IDLE;
          dm_done_d = 1'b1;
          if (!mem_we_q) begin
            dm_rdata_d = mem_rdata;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Stalls follow the requests directly so the pipeline freezes in the request cycle.
  assign stall_mem = dm_req & ~dm_done_q;
  assign stall_if  = (if_req & ~if_valid_q) | stall_mem;

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_done   = dm_done_q;
  assign busy      = busy_q;

endmodule

// File: doc/mem_port_sched.md
# mem_port_sched

Arbiter and sequencer for the single shared memory port of the SIMPLE pipeline. Instruction fetch (IF stage) and data access (LD/ST/PUSH/POP/GET/SET in MEM stage) both use one synchronous RAM. The block:
- grants the port to one requester at a time, with data having priority over fetch;
- counts out the fixed memory latency and returns read data;
- drives the stall lines that freeze the pipeline;
- discards fetches cancelled by a taken branch (`PC_load`).

## Interface
Parameters:
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `MEM_LAT`, 1, cycles from `mem_en` to valid `mem_rdata`; legal range 1..4

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; asynchronous, active-low (one clock domain)
- `if_req`  in  1  fetch request; held until `if_valid` or `flush`
- `if_addr`  in  ADDR_W  fetch address (PC)
- `if_rdata`  out  DATA_W  fetched instruction word
- `if_valid`  out  1  one-cycle pulse; `if_rdata` valid
- `dm_req`  in  1  data request; held until `dm_done`
- `dm_we`  in  1  1 = write (ST/PUSH/SET), 0 = read
- `dm_addr`  in  ADDR_W  data address
- `dm_wdata`  in  DATA_W  write data
- `dm_rdata`  out  DATA_W  read data
- `dm_done`  out  1  one-cycle pulse; access complete
- `flush`  in  1  taken branch; cancel pending or in-flight fetch
- `stall_if`  out  1  hold PC and IF/ID registers
- `stall_mem`  out  1  hold MEM stage and all earlier stages
- `mem_en`  out  1  memory access strobe, one cycle per access
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data
- `busy`  out  1  state is not IDLE

## Operation
- **States:** IDLE, FETCH_WAIT, DATA_WAIT. Latency counter `lat_cnt` is 3 bits.
- **IDLE, issue decision:**
  - If `dm_req`=1, issue the data access and go to DATA_WAIT.
  - Else if `if_req`=1 and `flush`=0, issue the fetch and go to FETCH_WAIT.
  - Else stay in IDLE.
- **Issue:** the address, we and wdata are registered onto the `mem_*` outputs, `mem_en` goes high for exactly one cycle, and `lat_cnt` is loaded with MEM_LAT. Fetches always issue with `mem_we`=0.
- **WAIT states:** `lat_cnt` decrements each cycle. When it reaches 0, `mem_rdata` is captured into `if_rdata` or `dm_rdata`. The next cycle pulses `if_valid` or `dm_done` and the state returns to IDLE.
- **Writes** occupy the port for the same duration as reads. `dm_rdata` is left unchanged on writes.
- **Flush:**
  - In FETCH_WAIT, `flush` sets a `discard` flag. At completion, `if_valid` is suppressed and `if_rdata` is unchanged; `discard` clears on return to IDLE.
  - In IDLE, `flush` blocks that cycle's fetch issue; data may still issue.
  - In DATA_WAIT, `flush` is ignored.
- **Stalls:**
  - `stall_mem` = `dm_req` & ~`dm_done`.
  - `stall_if` = (`if_req` & ~`if_valid`) | `stall_mem`.
- **Early request drop:** if `dm_req` drops mid-transaction, the access still completes and `dm_done` still pulses. A dropped `if_req` is equivalent to a flush for that fetch only if `flush` is asserted; otherwise `if_valid` pulses as normal.

## Timing
- **Reset values:** state IDLE; `mem_en`, `mem_we`, `if_valid`, `dm_done` and `busy` all 0; `mem_addr`, `mem_wdata`, `if_rdata` and `dm_rdata` all 0. Reset is asynchronous and applies immediately.
- **Reset mid-access:** `mem_en` drops at once, and any in-flight memory response is ignored.
- **Latency:** request sampled in cycle T → `mem_en` high in T+1 → `mem_rdata` sampled at end of T+1+MEM_LAT → `if_valid`/`dm_done` high in T+2+MEM_LAT.
- **Throughput:** the earliest next `mem_en` is T+3+MEM_LAT, i.e. one access per MEM_LAT+2 cycles.
- **Simultaneous `if_req` and `dm_req` in IDLE:** data wins; the fetch issues in the first IDLE cycle after `dm_done`.
- **Stall/pulse outputs:** `if_valid` and `dm_done` are registered; `stall_*` are combinational from `*_req` and the registered pulses.

## Structure
- Shared package `simple_pkg`:
  - `mem_state_t` enum (IDLE/FETCH_WAIT/DATA_WAIT)
  - constants `MEM_LAT_MIN`=1 and `MEM_LAT_MAX`=4
- An elaboration check rejects MEM_LAT outside that range.
- No sub-module; a single FSM plus counter is sufficient.

## Test plan
- **Single read, MEM_LAT=2:** `dm_req`=1, `dm_we`=0, `dm_addr`=16'h0040, memory returns 16'hBEEF → `mem_en` one cycle in T+1; `dm_done`=1 and `dm_rdata`=16'hBEEF in T+4; `stall_mem` high T..T+3.
- **Contention:** `if_req` (`if_addr`=16'h0010) and `dm_req` write (16'h0080 ← 16'h1234) both asserted in the same cycle → write issues first (`mem_we`=1); fetch `mem_en` follows in the first cycle after `dm_done`; `stall_if` stays high throughout.
- **Flush in flight:** fetch of 16'h0020 issued, `flush` pulsed in FETCH_WAIT → no `if_valid` pulse, `if_rdata` unchanged, state returns to IDLE after MEM_LAT+1 cycles.
- **Flush in IDLE:** `flush`=1 with `if_req`=1 → no `mem_en` that cycle; the fetch issues the next cycle if `if_req` is still high.
- **Back-to-back fetches, MEM_LAT=1:** PC 0, 1, 2 → `if_valid` pulses every 3 cycles with the correct words.
- **Reset mid-DATA_WAIT:** `rst_n`=0 asynchronously → `mem_en`, `dm_done` and `busy` are 0 immediately; after release, a new request issues normally.
